// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encodings for the up/down counter
//
// Purpose : mode constants and a small helper shared by the counter top.
// Ports   : none (package).
package counter_pkg;

  typedef logic [1:0] mode_t;

  // Encoding 2'b11 is unassigned and behaves as wrap.
  localparam mode_t MODE_WRAP    = 2'b00;
  localparam mode_t MODE_SAT     = 2'b01;
  localparam mode_t MODE_ONESHOT = 2'b10;

  // One-shot is the only mode that latches done on a boundary.
  function automatic logic is_oneshot(input mode_t m);
    return (m == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// rtl/prescaler_tick.sv - enable-gated prescaler producing a step tick
//
// Purpose : counts enabled cycles and asserts tick on every prescale+1'th one.
// Ports   : clk      - clock, rising edge
//           rst_n    - synchronous active-low reset
//           en       - count this cycle (hold and load both deasserted)
//           clr      - synchronous clear of the internal count
//           prescale - terminal value; tick when the count reaches it
//           tick     - combinational, high in the cycle the step is due
module prescaler_tick #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;
  logic             at_end;

  // >= rather than == so that lowering prescale below the current count
  // ends the period immediately instead of running through wrap-around.
  assign at_end = (pre_cnt >= prescale);
  assign tick   = en && at_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (at_end) pre_cnt <= '0;
      else        pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_updn_pro.sv
// rtl/counter_updn_pro.sv - prescaled up/down counter with wrap/saturate/one-shot
//
// Purpose : bounded 0..limit counter with load, hold, prescaler, terminal
//           count pulse, sticky overflow/underflow flags and one-shot done.
// Ports   : clk, rst_n          - clock and synchronous active-low reset
//           hold                - freeze counter and prescaler
//           up                  - 1 count up, 0 count down
//           mode                - 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//           load, load_val      - synchronous load (clamped to limit)
//           limit               - inclusive upper bound of the count
//           prescale            - step once every prescale+1 enabled cycles
//           clr_flags           - clear ovf/unf (a same-cycle set wins)
//           count, tc, ovf, unf, done - registered outputs
module counter_updn_pro
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             done
);

  logic             pre_en;
  logic             tick;
  logic             step;
  logic [WIDTH-1:0] nxt_count;
  logic             up_bnd;
  logic             dn_bnd;
  logic             set_ovf;
  logic             set_unf;

  // Load has priority over hold; either one stops the prescaler.
  assign pre_en = !hold && !load;

  prescaler_tick #(
    .PRE_W (PRE_W)
  ) u_pre (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (pre_en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  // A finished one-shot swallows ticks until the next load.
  assign step = tick && !done;

  always_comb begin
    nxt_count = count;
    up_bnd    = 1'b0;
    dn_bnd    = 1'b0;
    if (up) begin
      if (count >= limit) begin
        up_bnd = 1'b1;
        if (mode == MODE_SAT || mode == MODE_ONESHOT) nxt_count = limit;
        else                                          nxt_count = '0;
      end else begin
        nxt_count = count + 1'b1;
      end
    end else begin
      if (count > limit) begin
        // limit was lowered under the count: pull back in range, no boundary
        nxt_count = limit;
      end else if (count == '0) begin
        dn_bnd = 1'b1;
        if (mode == MODE_SAT || mode == MODE_ONESHOT) nxt_count = '0;
        else                                          nxt_count = limit;
      end else begin
        nxt_count = count - 1'b1;
      end
    end
  end

  assign set_ovf = step && up_bnd;
  assign set_unf = step && dn_bnd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      tc  <= 1'b0;
      // set dominates a simultaneous clear
      ovf <= set_ovf || (ovf && !clr_flags);
      unf <= set_unf || (unf && !clr_flags);
      if (load) begin
        count <= (load_val > limit) ? limit : load_val;
        done  <= 1'b0;
      end else if (step) begin
        count <= nxt_count;
        tc    <= up_bnd || dn_bnd;
        if ((up_bnd || dn_bnd) && is_oneshot(mode)) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_updn_pro.sv
// tb/tb_counter_updn_pro.sv - directed self-checking bench for counter_updn_pro
module tb_counter_updn_pro;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic       up;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [3:0] prescale;
  logic       clr_flags;
  logic [7:0] count;
  logic       tc;
  logic       ovf;
  logic       unf;
  logic       done;

  int compared;
  int mismatched;

  counter_updn_pro #(
    .WIDTH (8),
    .PRE_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .up        (up),
    .mode      (mode),
    .load      (load),
    .load_val  (load_val),
    .limit     (limit),
    .prescale  (prescale),
    .clr_flags (clr_flags),
    .count     (count),
    .tc        (tc),
    .ovf       (ovf),
    .unf       (unf),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0; hold = 1'b0; up = 1'b1; mode = 2'b00; load = 1'b0;
    load_val = 8'd0; limit = 8'd5; prescale = 4'd0; clr_flags = 1'b0;

    // reset state
    cyc();
    check("rst_count", count, 0);
    check("rst_tc", tc, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    check("rst_done", done, 0);

    // wrap up, limit 5, every cycle
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check("wrap_count", count, i);
      check("wrap_tc_low", tc, 0);
    end
    cyc();
    check("wrap_to_zero", count, 0);
    check("wrap_tc", tc, 1);
    check("wrap_ovf", ovf, 1);
    check("wrap_unf", unf, 0);
    cyc();
    check("wrap_after", count, 1);
    check("wrap_tc_one", tc, 0);

    // reset mid-operation at count 4 with ovf set
    cyc(); cyc(); cyc();
    check("pre_rst_count", count, 4);
    rst_n = 1'b0;
    cyc();
    check("midrst_count", count, 0);
    check("midrst_tc", tc, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_done", done, 0);
    rst_n = 1'b1;

    // clr_flags held through an up boundary: set wins, then clears
    clr_flags = 1'b1;
    repeat (5) cyc();
    check("clr_count5", count, 5);
    check("clr_ovf0", ovf, 0);
    cyc();
    check("clr_bnd_count", count, 0);
    check("clr_bnd_tc", tc, 1);
    check("clr_bnd_ovf", ovf, 1);
    cyc();
    check("clr_ovf_cleared", ovf, 0);
    clr_flags = 1'b0;

    // saturate down, prescale 2, load 2
    limit = 8'd9; prescale = 4'd2; up = 1'b0; mode = 2'b01;
    load = 1'b1; load_val = 8'd2;
    cyc();
    check("sat_load", count, 2);
    check("sat_load_tc", tc, 0);
    load = 1'b0;
    cyc(); cyc();
    check("sat_wait", count, 2);
    cyc();
    check("sat_step1", count, 1);
    repeat (3) cyc();
    check("sat_step0", count, 0);
    check("sat_step0_tc", tc, 0);
    check("sat_step0_unf", unf, 0);
    cyc(); cyc();
    check("sat_between_tc", tc, 0);
    cyc();
    check("sat_bnd_count", count, 0);
    check("sat_bnd_tc", tc, 1);
    check("sat_bnd_unf", unf, 1);
    cyc();
    check("sat_tc_drop", tc, 0);
    cyc(); cyc();
    check("sat_bnd2_tc", tc, 1);
    check("sat_bnd2_count", count, 0);

    // reset in the middle of a prescale period
    cyc();
    check("mid_pre_cnt", dut.u_pre.pre_cnt, 1);
    rst_n = 1'b0;
    cyc();
    check("prerst_pre_cnt", dut.u_pre.pre_cnt, 0);
    check("prerst_unf", unf, 0);
    rst_n = 1'b1;

    // one-shot up, limit 3
    limit = 8'd3; mode = 2'b10; up = 1'b1; prescale = 4'd0;
    load = 1'b1; load_val = 8'd0;
    cyc();
    load = 1'b0;
    check("os_load", count, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("os_count", count, i);
      check("os_done_low", done, 0);
    end
    cyc();
    check("os_bnd_count", count, 3);
    check("os_bnd_done", done, 1);
    check("os_bnd_tc", tc, 1);
    repeat (10) cyc();
    check("os_stay_count", count, 3);
    check("os_stay_done", done, 1);
    check("os_stay_tc", tc, 0);
    mode = 2'b00;
    cyc();
    check("os_mode_chg_done", done, 1);
    check("os_mode_chg_count", count, 3);
    mode = 2'b10;
    load = 1'b1; load_val = 8'd1;
    cyc();
    load = 1'b0;
    check("os_reload_count", count, 1);
    check("os_reload_done", done, 0);
    cyc();
    check("os_resume", count, 2);

    // one-shot down to a down boundary
    up = 1'b0;
    cyc();
    check("osd_1", count, 1);
    cyc();
    check("osd_0", count, 0);
    check("osd_0_done", done, 0);
    cyc();
    check("osd_bnd_done", done, 1);
    check("osd_bnd_unf", unf, 1);
    check("osd_bnd_tc", tc, 1);

    // load beats hold, load clamps to limit, hold freezes prescaler
    limit = 8'd100; prescale = 4'd3; mode = 2'b00; up = 1'b1;
    load = 1'b1; hold = 1'b1; load_val = 8'd200;
    cyc();
    check("prio_clamp", count, 100);
    check("prio_done", done, 0);
    load = 1'b0; hold = 1'b0;
    cyc();
    check("prio_pre1", dut.u_pre.pre_cnt, 1);
    hold = 1'b1;
    repeat (5) cyc();
    check("hold_count", count, 100);
    check("hold_pre", dut.u_pre.pre_cnt, 1);
    hold = 1'b0;
    cyc(); cyc();
    check("hold_release_wait", count, 100);
    cyc();
    check("hold_release_wrap", count, 0);
    check("hold_release_tc", tc, 1);

    // limit lowered below count on a down step: clamp, no boundary
    prescale = 4'd0;
    load = 1'b1; load_val = 8'd50;
    cyc();
    load = 1'b0;
    limit = 8'd20; up = 1'b0; clr_flags = 1'b1;
    cyc();
    check("lower_count", count, 20);
    check("lower_tc", tc, 0);
    check("lower_unf", unf, 0);
    clr_flags = 1'b0;

    // limit 0: every step is a boundary, count stays 0
    limit = 8'd0; up = 1'b1; load = 1'b1; load_val = 8'd7;
    cyc();
    load = 1'b0;
    check("lim0_load", count, 0);
    check("lim0_load_tc", tc, 0);
    cyc();
    check("lim0_a_count", count, 0);
    check("lim0_a_tc", tc, 1);
    cyc();
    check("lim0_b_tc", tc, 1);
    check("lim0_ovf", ovf, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/counter_updn_pro.md
COUNTER_UPDN_PRO -- requirements
Module: counter_updn_pro

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits.
REQ-002 The block SHALL have parameter PRE_W, default 4, giving the prescaler width in bits.
Ports:
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 The block SHALL have port hold, input, 1; 1 freezes the counter and the prescaler.
REQ-006 The block SHALL have port up, input, 1; 1 counts up, 0 counts down.
REQ-007 The block SHALL have port mode, input, 2: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-008 The block SHALL have port load, input, 1, a synchronous load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH, the load value.
REQ-010 The block SHALL have port limit, input, WIDTH, the inclusive upper bound; the count range is 0..limit.
REQ-011 The block SHALL have port prescale, input, PRE_W; the counter steps once every prescale+1 enabled cycles.
REQ-012 The block SHALL have port clr_flags, input, 1, which clears the ovf and unf flags.
REQ-013 The block SHALL have port count, output, WIDTH, the registered count value.
REQ-014 The block SHALL have port tc, output, 1, a one-cycle pulse on each boundary step.
REQ-015 The block SHALL have port ovf, output, 1, a sticky up-boundary flag.
REQ-016 The block SHALL have port unf, output, 1, a sticky down-boundary flag.
REQ-017 The block SHALL have port done, output, 1; 1 when a one-shot count has finished.

Function
REQ-018 Update priority SHALL be: reset > load > hold > step.
REQ-019 Load SHALL set count = min(load_val, limit) on the next edge, clear the prescaler and done, and SHALL NOT generate tc.
REQ-020 Prescaler behaviour:
- The prescaler (pre_cnt) SHALL increment on each cycle where hold=0 and load=0.
- tick SHALL be asserted when pre_cnt == prescale; pre_cnt then returns to 0.
- prescale=0 SHALL give a step every cycle.
REQ-021 A step SHALL occur only on a tick with done=0; otherwise count is unchanged.
REQ-022 Up step with count < limit SHALL give count+1; down step with 0 < count <= limit SHALL give count-1.
REQ-023 An up step with count >= limit is an up boundary; the result SHALL be: wrap -> 0; saturate -> limit; one-shot -> limit, and done SHALL set.
REQ-024 A down step with count == 0 is a down boundary; the result SHALL be: wrap -> limit; saturate -> 0; one-shot -> 0, and done SHALL set.
REQ-025 A down step with count > limit (limit lowered mid-count) SHALL give count = limit and SHALL NOT be a boundary.
REQ-026 tc SHALL be high for exactly the cycle after each boundary step, in every mode, including repeated saturate boundaries.
REQ-027 ovf SHALL set on an up boundary and unf on a down boundary; both stay set until clr_flags; a set and a clear in the same cycle SHALL leave the flag set.
REQ-028 done SHALL stay high until load or reset; mode changes SHALL NOT clear it.
REQ-029 With limit=0 the count SHALL stay at 0, and every step SHALL be a boundary.
REQ-030 All outputs SHALL be registered; count SHALL change one edge after the tick cycle.

Reset
REQ-031 When rst_n=0 at a rising edge: count=0, pre_cnt=0, tc=0, ovf=0, unf=0, done=0.
REQ-032 Reset SHALL override load, hold and steps in the same cycle, including in the middle of a prescale period.
REQ-033 No initial blocks SHALL be relied on for the reset state.

Structure
REQ-034 Mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) SHALL be defined as constants in shared package counter_pkg.
REQ-035 The prescaler SHALL be a sub-module, prescaler_tick, with ports clk, rst_n, en, clr, prescale and tick.
REQ-036 The counter datapath and flags SHALL be in the top module.

Verification
REQ-037 Wrap, up: WIDTH=8, limit=5, prescale=0, up=1, mode=00, from reset -> count 1,2,3,4,5,0; tc high in the cycle count shows 0; ovf=1.
REQ-038 Saturate, down, prescaled: limit=9, prescale=2, up=0, mode=01, load 2 -> count changes every 3 cycles: 1, then 0, then stays 0; tc pulses on each later tick; unf=1.
REQ-039 One-shot: limit=3, mode=10, up=1, load 0 -> count 1,2,3; done=1 and count stays 3 for 10 cycles; load 1 -> done=0 and counting resumes.
REQ-040 Priority: load=1 and hold=1 with load_val=200 and limit=100 -> count=100; then hold=1 for 5 cycles -> count and pre_cnt unchanged.
REQ-041 Reset mid-operation and flags:
- rst_n=0 for 1 cycle while count=4 and ovf=1 -> all outputs 0 the next cycle.
- clr_flags=1 in the same cycle as an up boundary -> ovf stays 1.
